// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared arithmetic constants and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam int ARITH_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module      : full_sub
// Description : Combinational 1-bit full subtractor (d = a - b - bi).
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial W-bit unsigned subtractor, LSB first, with a
//               start/busy/done handshake. Macro SERIAL_SUB_OVF_EN enables
//               the signed-overflow flag; otherwise ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int W     = ARITH_W,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    state_t             state;
    state_t             state_nxt;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-2:0]       diff_sh;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               bit_d;
    logic               bit_bo;
    logic               last;
    logic [W-1:0]       diff_full;

    full_sub u_full_sub (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (br),
        .d  (bit_d),
        .bo (bit_bo)
    );

    assign last      = (cnt == CNT_W'(W - 1));
    assign diff_full = {bit_d, diff_sh};
    assign busy      = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_full[W-1:1];
                    br      <= bit_bo;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        diff <= diff_full;
                        bout <= bit_bo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // On the last RUN edge the shift registers present the operand MSBs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == ST_RUN && last) begin
            ovf_q <= (a_sh[0] != b_sh[0]) && (bit_d != a_sh[0]);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor with directed and
//               random operand pairs (honours SERIAL_SUB_OVF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    serial_subtractor #(.W(W), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int d;
        int bo;
        int ov;
        int at;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input int x, input int y, input int at);
        exp_t e;
        int   m  = 1 << W;
        int   h  = 1 << (W - 1);
        int   sx = (x >= h) ? x - m : x;
        int   sy = (y >= h) ? y - m : y;
        int   sr = sx - sy;
        e.d  = (x - y + m) % m;
        e.bo = (x < y) ? 1 : 0;
`ifdef SERIAL_SUB_OVF_EN
        e.ov = (sr < -h || sr > h - 1) ? 1 : 0;
`else
        e.ov = (sr == sr + 1) ? 1 : 0;
`endif
        e.at = at;
        return e;
    endfunction

    // Waits for IDLE, applies one start pulse and records the expected result.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        int g = 0;
        @(negedge clk);
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("issue_timeout", 1, 0);
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(int'(x), int'(y), cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    initial begin
        int   bc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0;
            end else begin
                if (done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("diff", int'(diff), e.d);
                        check("bout", int'(bout), e.bo);
                        check("ovf", int'(ovf), e.ov);
                        check("latency", cyc, e.at);
                        check("busy_len", bc, W);
                    end
                    bc = 0;
                end
                if (busy) bc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_ovf",  int'(ovf),  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed pairs; successive issues land in the done cycle (back-to-back).
        issue(4'b0100, 4'b0001);
        issue(4'b0001, 4'b0111);
        issue(4'b0101, 4'b0101);
        issue(4'b0111, 4'b1000);
        issue(4'b1100, 4'b1001);
        issue(4'b0000, 4'b1011);

        // Start while busy must be ignored.
        issue(4'b0011, 4'b0010);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        b     = 4'b0000;
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in the second RUN cycle.
        issue(4'b1001, 4'b0011);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_bout", int'(bout), 0);
        check("midrst_ovf",  int'(ovf),  0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(4'b1101, 4'b0000);

        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom));
        end

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
